// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and sequential clear sweep
// Ports: clk/rst (sync, active-high); rd_addr/rd_data/rd_busy = NRD packed combinational read ports;
// wp0_*/wp1_* = write ports (wp1 wins on same address, *_clr also clears busy);
// mark_en/mark_addr = set busy bit; clr_req = start zeroing sweep; clr_busy/wr_ready = sweep status.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle writes and busy updates to the read ports.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wp0_en,
    input  logic [ADDR_W-1:0]     wp0_addr,
    input  logic [DATA_W-1:0]     wp0_data,
    input  logic                  wp0_clr,
    input  logic                  wp1_en,
    input  logic [ADDR_W-1:0]     wp1_addr,
    input  logic [DATA_W-1:0]     wp1_data,
    input  logic                  wp1_clr,
    input  logic                  mark_en,
    input  logic [ADDR_W-1:0]     mark_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  wr_ready
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              w0, w1;

    assign clr_busy = state_q == SWEEP;
    assign wr_ready = !clr_busy;
    assign w0 = wp0_en && wp0_addr != '0 && wr_ready;
    assign w1 = wp1_en && wp1_addr != '0 && wr_ready;

    // Entry 0 is never written, so it stays zero and never busy.
    always_comb begin
        mem_d   = mem_q;
        busy_d  = busy_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (w0) mem_d[wp0_addr] = wp0_data;
        if (w1) mem_d[wp1_addr] = wp1_data;
        if (w0 && wp0_clr) busy_d[wp0_addr] = 1'b0;
        if (w1 && wp1_clr) busy_d[wp1_addr] = 1'b0;
        if (mark_en && mark_addr != '0) busy_d[mark_addr] = 1'b1;
        if (state_q == SWEEP) begin
            mem_d[idx_q] = '0;
            idx_d        = idx_q + 1'b1;
            state_d      = &idx_q ? IDLE : SWEEP;
        end else if (clr_req) begin
            state_d = SWEEP;
            idx_d   = ADDR_W'(1);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rd_data[k*DATA_W +: DATA_W] = a == '0 ? '0 :
                                             (w1 && wp1_addr == a) ? wp1_data :
                                             (w0 && wp0_addr == a) ? wp0_data : mem_q[a];
        assign rd_busy[k] = a != '0 && busy_d[a];
`else
        assign rd_data[k*DATA_W +: DATA_W] = a == '0 ? '0 : mem_q[a];
        assign rd_busy[k] = a != '0 && busy_q[a];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based reference model
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wp0_en, wp0_clr, wp1_en, wp1_clr, mark_en, clr_req, clr_busy, wr_ready;
    logic [AW-1:0]  wp0_addr, wp1_addr, mark_addr;
    logic [DW-1:0]  wp0_data, wp1_data;

    logic [11:0]    b_rd_addr;
    logic [63:0]    b_rd_data;
    logic [3:0]     b_rd_busy;
    logic           b_wp0_en, b_clr_busy, b_wr_ready;
    logic [2:0]     b_wp0_addr;
    logic [15:0]    b_wp0_data;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wp0_en(wp0_en), .wp0_addr(wp0_addr), .wp0_data(wp0_data), .wp0_clr(wp0_clr),
        .wp1_en(wp1_en), .wp1_addr(wp1_addr), .wp1_data(wp1_data), .wp1_clr(wp1_clr),
        .mark_en(mark_en), .mark_addr(mark_addr), .clr_req(clr_req),
        .clr_busy(clr_busy), .wr_ready(wr_ready)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4)) dut4 (
        .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wp0_en(b_wp0_en), .wp0_addr(b_wp0_addr), .wp0_data(b_wp0_data), .wp0_clr(1'b0),
        .wp1_en(1'b0), .wp1_addr(3'd0), .wp1_data(16'd0), .wp1_clr(1'b0),
        .mark_en(1'b0), .mark_addr(3'd0), .clr_req(1'b0),
        .clr_busy(b_clr_busy), .wr_ready(b_wr_ready)
    );

    logic [DW-1:0] m_mem [DEPTH];
    logic          m_busy [DEPTH];
    logic          m_sweep;
    int            m_ptr;
    int            n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic acc(input logic en, input logic [AW-1:0] a);
        return en && a != 0 && !m_sweep;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (acc(wp1_en, wp1_addr) && wp1_addr == a) return wp1_data;
        if (acc(wp0_en, wp0_addr) && wp0_addr == a) return wp0_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (mark_en && mark_addr == a) return 1'b1;
        if ((acc(wp0_en, wp0_addr) && wp0_clr && wp0_addr == a) ||
            (acc(wp1_en, wp1_addr) && wp1_clr && wp1_addr == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_sweep = 1'b0;
            m_ptr   = 0;
        end else begin
            logic a0, a1;
            a0 = acc(wp0_en, wp0_addr);
            a1 = acc(wp1_en, wp1_addr);
            if (a0) m_mem[wp0_addr] = wp0_data;
            if (a1) m_mem[wp1_addr] = wp1_data;
            if (a0 && wp0_clr) m_busy[wp0_addr] = 1'b0;
            if (a1 && wp1_clr) m_busy[wp1_addr] = 1'b0;
            if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
            if (m_sweep) begin
                m_mem[m_ptr] = '0;
                m_ptr++;
                if (m_ptr == DEPTH) m_sweep = 1'b0;
            end else if (clr_req) begin
                m_sweep = 1'b1;
                m_ptr   = 1;
            end
        end
    endtask

    task automatic step();
        logic [AW-1:0] a;
        #1;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            check("rd_data", 64'(rd_data[k*DW +: DW]), 64'(exp_data(a)));
            check("rd_busy", 64'(rd_busy[k]), 64'(exp_busy(a)));
        end
        check("clr_busy", 64'(clr_busy), 64'(m_sweep));
        check("wr_ready", 64'(wr_ready), 64'(!m_sweep));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; wp0_en = 0; wp0_clr = 0; wp1_en = 0; wp1_clr = 0; mark_en = 0; clr_req = 0;
    endtask

    task automatic read_all();
        idle();
        for (int i = 0; i < DEPTH; i += 2) begin
            rd_addr = {AW'(i + 1), AW'(i)};
            step();
        end
    endtask

    task automatic load_all(input logic mark);
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            wp0_en = 1; wp0_addr = AW'(i); wp0_data = DW'(i);
            mark_en = mark; mark_addr = AW'(i);
            step();
        end
        idle();
    endtask

    initial begin
        int cnt;
        idle();
        rst = 1;
        rd_addr = '0; wp0_addr = '0; wp1_addr = '0; mark_addr = '0; wp0_data = '0; wp1_data = '0;
        b_rd_addr = '0; b_wp0_en = 0; b_wp0_addr = '0; b_wp0_data = '0;
        repeat (2) begin
            @(posedge clk);
            model_update();
        end
        @(negedge clk);
        idle();

        rd_addr = {5'd7, 5'd0};
        step();
        check("rst_rd7", 64'(rd_data[2*DW-1:DW]), 64'd0);
        check("rst_busy", 64'(rd_busy), 64'd0);
        wp0_en = 1; wp0_addr = 0; wp0_data = 32'hDEADBEEF; rd_addr = '0;
        step();
        idle();
        step();
        check("zero_reg", 64'(rd_data[DW-1:0]), 64'd0);

        wp0_en = 1; wp0_addr = 5; wp0_data = 32'h11111111;
        wp1_en = 1; wp1_addr = 5; wp1_data = 32'h22222222;
        rd_addr = {5'd5, 5'd5};
        step();
        idle();
        check("wp1_wins", 64'(rd_data[DW-1:0]), 64'h22222222);
        step();

        rd_addr = {5'd9, 5'd9};
        mark_en = 1; mark_addr = 9;
        step();
        idle();
        check("mark", 64'(rd_busy[0]), 64'd1);
        wp0_en = 1; wp0_addr = 9; wp0_data = 32'h99; wp0_clr = 1;
        step();
        idle();
        check("busy_clr", 64'(rd_busy[0]), 64'd0);
        mark_en = 1; mark_addr = 9; wp1_en = 1; wp1_addr = 9; wp1_data = 32'h9; wp1_clr = 1;
        step();
        idle();
        check("mark_prio", 64'(rd_busy[0]), 64'd1);
        step();

        load_all(1'b0);
        clr_req = 1;
        step();
        clr_req = 0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            if (cnt == 5) begin
                wp0_en = 1; wp0_addr = 3; wp0_data = 32'hAA;
            end
            if (cnt == 8) clr_req = 1;
            rd_addr = {AW'(cnt), 5'd3};
            step();
            idle();
            cnt++;
        end
        check("sweep_len", 64'(cnt), 64'd31);
        read_all();
        rd_addr = {5'd3, 5'd31};
        #1;
        check("swept3", 64'(rd_data[2*DW-1:DW]), 64'd0);
        check("swept31", 64'(rd_data[DW-1:0]), 64'd0);

        load_all(1'b1);
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (9) step();
        rst = 1;
        step();
        idle();
        check("rst_sweep_busy", 64'(clr_busy), 64'd0);
        check("rst_sweep_ready", 64'(wr_ready), 64'd1);
        read_all();

        repeat (3000) begin
            rst     = $urandom_range(0, 299) == 0;
            clr_req = $urandom_range(0, 79) == 0;
            wp0_en  = 1'($urandom);
            wp0_clr = 1'($urandom);
            wp0_addr = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wp0_data = $urandom;
            wp1_en  = 1'($urandom);
            wp1_clr = 1'($urandom);
            wp1_addr = $urandom_range(0, 2) == 0 ? wp0_addr : AW'($urandom);
            wp1_data = $urandom;
            mark_en = 1'($urandom);
            mark_addr = $urandom_range(0, 2) == 0 ? wp1_addr : AW'($urandom);
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 3))
                    0: rd_addr[k*AW +: AW] = wp0_addr;
                    1: rd_addr[k*AW +: AW] = wp1_addr;
                    2: rd_addr[k*AW +: AW] = mark_addr;
                    default: rd_addr[k*AW +: AW] = AW'($urandom);
                endcase
            end
            step();
        end
        idle();
        step();

        for (int i = 1; i < 8; i++) begin
            b_wp0_en = 1; b_wp0_addr = 3'(i); b_wp0_data = 16'(i * 16'h0101);
            @(posedge clk);
            @(negedge clk);
        end
        b_wp0_en = 0;
        b_rd_addr = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        for (int k = 0; k < 4; k++)
            check("nrd4", 64'(b_rd_data[k*16 +: 16]), 64'((2 * k + 1) * 16'h0101));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipelined CPU. It replaces the fixed 32x32 2R1W file.
- NRD combinational read ports and two prioritised write ports (wp0 = ALU writeback, wp1 = load/MDU writeback).
- Per-register busy scoreboard used by hazard detection.
- Sequential clear engine that zeroes the array on request without a full reset.
- Register 0 reads zero, ignores writes and is never busy.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
NRD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NRD  busy bit of each addressed register
wp0_en  in  1  write port 0 enable
wp0_addr  in  ADDR_W  write port 0 index
wp0_data  in  DATA_W  write port 0 data
wp0_clr  in  1  also clear busy bit of wp0_addr on this write
wp1_en / wp1_addr / wp1_data / wp1_clr  in  1/ADDR_W/DATA_W/1  write port 1, same meaning
mark_en  in  1  set busy bit of mark_addr
mark_addr  in  ADDR_W  register to mark busy
clr_req  in  1  start clear sweep (pulse)
clr_busy  out  1  clear sweep in progress
wr_ready  out  1  writes accepted this cycle (= !clr_busy)

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high: all actions occur on the posedge of clk.

Reset (rst=1 at posedge):
- All DEPTH registers are set to 0 and all busy bits to 0.
- The FSM goes to IDLE, so clr_busy=0 and wr_ready=1.
- rst overrides every other input in the same cycle.

Reads:
- Reads are combinational, with zero latency.
- Address 0 returns 0 and rd_busy=0.
- Any other address returns the stored value, and rd_busy returns the stored busy bit.

Writes:
- A write commits at the posedge when en=1, addr!=0 and wr_ready=1.
- Writes to address 0 are dropped silently.
- If wp0 and wp1 target the same address in the same cycle, wp1 wins the data.
- The busy clear for that address applies if either port has clr=1.

Scoreboard:
- mark_en sets busy[mark_addr] at the posedge. mark_addr=0 is ignored.
- If the same cycle both marks and clears an address (via wp*_clr), the mark wins and busy=1.
- Busy bits are unaffected by a clear sweep.

Clear FSM:
- States IDLE and SWEEP. A 0..DEPTH-1 index counter is held in the FSM.
- IDLE -> SWEEP when clr_req=1; the index is loaded with 1.
- SWEEP writes 0 to registers[idx] each cycle and increments idx.
- SWEEP -> IDLE in the cycle idx wraps from DEPTH-1. The sweep takes DEPTH-1 cycles with clr_busy=1.
- clr_req during SWEEP is ignored; the sweep does not restart.
- wr_ready=0 throughout SWEEP. Writes presented then are dropped, and it is the source's job to stall. Marks are still accepted.
- Reads during SWEEP return the current contents: already-swept entries read 0, the rest read old values.
- rst mid-sweep zeroes everything and returns to IDLE.

Optional Feature:
Macro: REGFILE_BYPASS_EN

With the macro defined:
- A read whose address matches an accepted write in the same cycle returns the incoming write data, not the stored value.
- If both write ports match, the wp1 data is returned.
- Address 0 still reads 0.
- rd_busy reflects the post-update busy value: a matching clr forwards 0, a matching mark forwards 1, and mark priority holds.

Without the macro:
- Reads return pre-edge stored values and busy bits only.
- A same-cycle write is visible from the next cycle.

Test Plan:
1. Reset then read all ports at addr 0 and 7 -> rd_data=0 and rd_busy=0 everywhere. Write wp0 addr 0 data 0xDEADBEEF -> addr 0 still reads 0.
2. Same cycle, wp0 addr 5 data 0x11111111 and wp1 addr 5 data 0x22222222 -> next cycle rd_data for addr 5 = 0x22222222. Without the macro, the same-cycle read returns the old value 0. With REGFILE_BYPASS_EN, the same-cycle read returns 0x22222222.
3. mark_en addr 9 -> rd_busy=1 next cycle. wp0 addr 9 with clr=1 -> busy=0 next cycle. Simultaneous mark 9 plus wp1_clr 9 -> busy stays 1.
4. Load regs 1..31 with their own index, then pulse clr_req:
   - clr_busy=1 and wr_ready=0 for exactly 31 cycles; all regs read 0 afterwards.
   - A wp0 write to addr 3 of 0xAA mid-sweep is dropped, and addr 3 reads 0 after the sweep.
   - A second clr_req mid-sweep leaves the length at 31.
5. Assert rst at sweep cycle 10 -> the next cycle shows clr_busy=0, wr_ready=1, all regs and busy bits 0.
6. NRD=4, ADDR_W=3, DATA_W=16: write addr 1..7 with the value index*0x101 -> four ports reading 1, 3, 5, 7 return 0x0101, 0x0303, 0x0505, 0x0707.
